// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared types, widths, limits and default coefficients for fir_tap_sequencer
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } fir_state_e;

    localparam int SAMPLE_W = 8;
    localparam int COEF_W   = 8;
    localparam int OUT_W    = 16;
    localparam int PROD_W   = SAMPLE_W + COEF_W;

    localparam int SAT_MAX  = 32767;
    localparam int SAT_MIN  = -32768;

    // Reset-state coefficient for tap i is simply i+1.
    function automatic logic signed [COEF_W-1:0] default_coef(input int i);
        return COEF_W'(i + 1);
    endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// rtl/fir_mac_unit.sv - shared signed 8x8 multiply-accumulate with clear/enable and saturating narrow
module fir_mac_unit
    import fir_seq_pkg::*;
#(
    parameter int ACC_W = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] a,
    input  logic signed [COEF_W-1:0]   b,
    output logic signed [OUT_W-1:0]    sat_next
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(SAT_MIN);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;

    // Full-width product, sign-extended and added to the running sum.
    always_comb begin
        prod     = a * b;
        acc_next = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

    // Clamp the sum that includes this cycle's product, so the last tap can be latched directly.
    always_comb begin
        if (acc_next > ACC_MAX) begin
            sat_next = OUT_W'(SAT_MAX);
        end else if (acc_next < ACC_MIN) begin
            sat_next = OUT_W'(SAT_MIN);
        end else begin
            sat_next = acc_next[OUT_W-1:0];
        end
    end

    // Accumulator register: clear wins over enable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// rtl/fir_tap_sequencer.sv - time-multiplexed N-tap FIR sequencer; FIR_TAP_SEQ_COEF_WRITE_EN adds coefficient writes
module fir_tap_sequencer
    import fir_seq_pkg::*;
#(
    parameter int N     = 4,
    parameter int ACC_W = 16 + $clog2(N)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] x_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [OUT_W-1:0]    y_out,
    output logic                       out_valid,
    input  logic                       out_ready,
`ifdef FIR_TAP_SEQ_COEF_WRITE_EN
    input  logic                       coef_we,
    input  logic [3:0]                 coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
`endif
    output logic                       busy
);

    localparam int K_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_MAC  = MAC;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]                 state;
    logic [K_W-1:0]             k;
    logic signed [SAMPLE_W-1:0] x_reg [N];
    logic signed [COEF_W-1:0]   h     [N];
    logic                       accept;
    logic                       last_tap;
    logic signed [OUT_W-1:0]    sat_next;

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign last_tap = (state == S_MAC) && (k == K_W'(N - 1));

    fir_mac_unit #(
        .ACC_W (ACC_W)
    ) u_mac (
        .clk      (clk),
        .reset    (reset),
        .clear    (accept),
        .en       (state == S_MAC),
        .a        (x_reg[k]),
        .b        (h[k]),
        .sat_next (sat_next)
    );

    // Sequencer FSM, tap counter and registered output handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            k         <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_MAC;
                        k     <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_MAC: begin
                    k <= k + K_W'(1);
                    if (last_tap) begin
                        state     <= S_DONE;
                        y_out     <= sat_next;
                        out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Delay line shifts only when a sample is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                x_reg[i] <= '0;
            end
        end else if (accept) begin
            x_reg[0] <= x_in;
            for (int i = 1; i < N; i++) begin
                x_reg[i] <= x_reg[i-1];
            end
        end
    end

`ifdef FIR_TAP_SEQ_COEF_WRITE_EN
    // Writable coefficients: only in IDLE, out-of-range addresses dropped; a write alongside an accept lands before the first MAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                h[i] <= default_coef(i);
            end
        end else if ((state == S_IDLE) && coef_we && (32'(coef_addr) < N)) begin
            h[coef_addr[K_W-1:0]] <= coef_data;
        end
    end
`else
    // Fixed coefficients taken from the reset-state table.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            h[i] = default_coef(i);
        end
    end
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb/tb_fir_tap_sequencer.sv - directed self-checking bench for fir_tap_sequencer
module tb_fir_tap_sequencer;

    localparam int N = 4;

    logic              clk;
    logic              reset;
    logic signed [7:0] x_in;
    logic              in_valid;
    logic              in_ready;
    logic signed [15:0] y_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              coef_we;
    logic [3:0]        coef_addr;
    logic signed [7:0] coef_data;

    int tests;
    int fails;

    fir_tap_sequencer #(
        .N (N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef FIR_TAP_SEQ_COEF_WRITE_EN
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [31:0] ysx();
        return {{16{y_out[15]}}, y_out};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One sample through the pipe: accept, latency check, result, optional backpressure, handshake.
    task automatic send(input logic signed [7:0] x, input int exp, input int hold,
                        input bit wr_busy, input bit wr_acc, input string tag);
        int cnt;
        chk({tag, "_in_ready_pre"}, {31'b0, in_ready}, 1);
        x_in      = x;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        if (wr_acc) begin
            coef_we   = 1'b1;
            coef_addr = 4'd0;
            coef_data = 8'sd9;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 1);
        chk({tag, "_in_ready_mac"}, {31'b0, in_ready}, 0);
        if (wr_busy) begin
            coef_we   = 1'b1;
            coef_addr = 4'd0;
            coef_data = 8'sd9;
        end
        cnt = 0;
        while (out_valid !== 1'b1 && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        coef_we = 1'b0;
        chk({tag, "_latency"}, 32'(cnt), 32'(N));
        chk({tag, "_y"}, ysx(), 32'(exp));
        if (hold > 0) begin
            x_in     = 8'sd50;
            in_valid = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_valid"}, {31'b0, out_valid}, 1);
                chk({tag, "_hold_y"}, ysx(), 32'(exp));
                chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_in_ready_post"}, {31'b0, in_ready}, 1);
        chk({tag, "_out_valid_post"}, {31'b0, out_valid}, 0);
        chk({tag, "_busy_post"}, {31'b0, busy}, 0);
        chk({tag, "_y_retained"}, ysx(), 32'(exp));
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        x_in      = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_in_ready", {31'b0, in_ready}, 1);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_y", ysx(), 0);
        chk("rst_busy", {31'b0, busy}, 0);

        // Impulse with default coefficients 1..4.
        send(8'sd1, 1, 0, 1'b0, 1'b0, "imp0");
        send(8'sd0, 2, 0, 1'b0, 1'b0, "imp1");
        send(8'sd0, 3, 0, 1'b0, 1'b0, "imp2");
        send(8'sd0, 4, 0, 1'b0, 1'b0, "imp3");

        // Step of 127.
        send(8'sd127, 127,  0, 1'b0, 1'b0, "step0");
        send(8'sd127, 381,  0, 1'b0, 1'b0, "step1");
        send(8'sd127, 762,  0, 1'b0, 1'b0, "step2");
        send(8'sd127, 1270, 0, 1'b0, 1'b0, "step3");

        // Backpressure: 127*(2+3+4), then a held offer of 50 must not enter the delay line.
        send(8'sd0, 1143, 5, 1'b0, 1'b0, "bp");
        send(8'sd0, 889,  0, 1'b0, 1'b0, "bp_after");

        // Reset while k = 2.
        x_in     = 8'sd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 1);
        chk("mid_rst_y", ysx(), 0);
        chk("mid_rst_busy", {31'b0, busy}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        send(8'sd1, 1, 0, 1'b0, 1'b0, "post_rst0");
        send(8'sd0, 2, 0, 1'b0, 1'b0, "post_rst1");

`ifdef FIR_TAP_SEQ_COEF_WRITE_EN
        // Write during MAC is ignored.
        do_reset();
        send(8'sd1, 1, 0, 1'b1, 1'b0, "wr_busy");
        // Write coincident with accept takes effect for that sample.
        do_reset();
        send(8'sd1, 9, 0, 1'b0, 1'b1, "wr_acc");
        // All coefficients to 127, then saturate both ways.
        for (int i = 0; i < N; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = 8'sd127;
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
        send(-8'sd128, -16129, 0, 1'b0, 1'b0, "sat_n0");
        send(-8'sd128, -32385, 0, 1'b0, 1'b0, "sat_n1");
        send(-8'sd128, -32768, 0, 1'b0, 1'b0, "sat_n2");
        send(-8'sd128, -32768, 0, 1'b0, 1'b0, "sat_n3");
        send(8'sd127, -32639, 0, 1'b0, 1'b0, "sat_p0");
        send(8'sd127, -254,   0, 1'b0, 1'b0, "sat_p1");
        send(8'sd127, 32131,  0, 1'b0, 1'b0, "sat_p2");
        send(8'sd127, 32767,  0, 1'b0, 1'b0, "sat_p3");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
